dm_lsu: RTL and testbench

Load/store unit that drives the single-port, word-addressed data memory (1024 × 32, synchronous write, registered read with one-cycle latency) on behalf of the pipeline's MEM stage. It accepts one byte-addressed load or store request at a time through a valid/ready handshake. It sequences the memory port, and performs read-modify-write for byte and halfword stores. It returns sign- or zero-extended load data with a one-cycle `rsp_valid` pulse.

---
 rtl/dm_lsu.sv | 137 +++++++++++++
 tb/tb_dm_lsu.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_lsu.sv
// Load/store sequencer for a 1024x32 single-port data memory with registered read. Latency is 1 cycle for a word store,
// 2 for a load and 3 for a sub-word store. Accepts one request at a time and is ready only in IDLE or DONE.
module dm_lsu #(
    parameter int bit_width      = 32,
    parameter int word_idx_width = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [bit_width-1:0] req_addr,
    input  logic [bit_width-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [bit_width-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [bit_width-1:0] dm_addr,
    output logic [bit_width-1:0] dm_din,
    output logic                 dm_wr,
    input  logic [bit_width-1:0] dm_dout
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_t;

    typedef struct packed {
        logic                      we;
        logic [1:0]                size;
        logic                      uns;
        logic [1:0]                lo;
        logic [word_idx_width-1:0] idx;
    } req_t;

    state_t               state, state_nxt;
    req_t                 req_q;
    logic [bit_width-1:0] din_q, rdata_q, load_val, merged;
    logic                 err_q, accept, misaligned;
    logic [7:0]           lane_b;
    logic [15:0]          lane_h;
    logic                 unused_addr_hi;

    // High address bits are dropped on purpose: the memory aliases every 4 KiB.
    assign unused_addr_hi = ^req_addr[bit_width-1:word_idx_width+2];

    assign misaligned = (req_size == 2'b11)
                      | ((req_size == 2'b01) & req_addr[0])
                      | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        dm_wr     = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                req_ready = 1'b1;
                rsp_valid = (state == DONE);
                if (req_valid) begin
                    accept = 1'b1;
                    if (misaligned)                          state_nxt = DONE;
                    else if (req_we && req_size == 2'b10)    state_nxt = WR;
                    else                                     state_nxt = RD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RD:      state_nxt = WAIT;
            WAIT:    state_nxt = req_q.we ? WR : DONE;
            WR: begin
                dm_wr     = 1'b1;
                state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset wins over everything so an aborted WR never reaches the memory.
        if (rst) begin
            req_ready = 1'b0;
            rsp_valid = 1'b0;
            dm_wr     = 1'b0;
            accept    = 1'b0;
        end
    end

    always_comb begin
        lane_b = dm_dout[{req_q.lo, 3'b000} +: 8];
        lane_h = req_q.lo[1] ? dm_dout[31:16] : dm_dout[15:0];
        case (req_q.size)
            2'b00:   load_val = {{(bit_width-8){~req_q.uns & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{(bit_width-16){~req_q.uns & lane_h[15]}}, lane_h};
            default: load_val = dm_dout;
        endcase
        merged = dm_dout;
        case (req_q.size)
            2'b00:   merged[{req_q.lo, 3'b000} +: 8]      = din_q[7:0];
            2'b01:   merged[{req_q.lo[1], 4'b0000} +: 16] = din_q[15:0];
            default: merged = dm_dout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                req_q <= '{we: req_we, size: req_size, uns: req_unsigned,
                           lo: req_addr[1:0], idx: req_addr[word_idx_width+1:2]};
                err_q <= misaligned;
                if (req_we) din_q <= req_wdata;
            end
            // din_q keeps the right-aligned store data until the merge replaces it.
            if (state == WAIT) begin
                if (req_q.we) begin
                    din_q <= merged;
                end else begin
                    rdata_q <= load_val;
                    err_q   <= 1'b0;
                end
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign dm_din    = din_q;
    assign dm_addr   = {{(bit_width-word_idx_width){1'b0}}, req_q.idx};

endmodule

// File: tb/tb_dm_lsu.sv
// Randomized bench for dm_lsu with a behavioural memory and a byte-lane reference model.
module tb_dm_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, dm_wr;
    logic [31:0] rsp_rdata, dm_addr, dm_din, dm_dout;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] last_rdata;
    logic [31:0] got;
    int          n_chk = 0;
    int          n_fail = 0;

    dm_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_wr(dm_wr), .dm_dout(dm_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dm_wr) mem[dm_addr[9:0]] <= dm_din;
        dm_dout <= mem[dm_addr[9:0]];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_eq("idle_rsp_valid", rsp_valid, 1'b0);
            chk_eq("idle_dm_wr", dm_wr, 1'b0);
        end
    endtask

    // Called at a negedge; returns at the negedge of the response cycle.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input bit b2b, output logic [31:0] rd);
        int          idx, sh, exp_lat, exp_wr, c, wr, waddr, wait_c;
        logic        exp_err;
        logic [31:0] exp_rd, w, mask, v;
        idx     = int'(addr[11:2]);
        sh      = 8 * int'(addr[1:0]);
        exp_err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        exp_rd  = last_rdata;
        exp_wr  = 0;
        if (exp_err) begin
            exp_lat = 0;
        end else if (we) begin
            exp_wr = 1;
            if (size == 2'd2) begin
                exp_lat      = 1;
                ref_mem[idx] = wdata;
            end else begin
                exp_lat      = 3;
                mask         = (size == 2'd0 ? 32'hFF : 32'hFFFF) << sh;
                ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wdata << sh) & mask);
            end
        end else begin
            exp_lat = 2;
            w       = ref_mem[idx];
            if (size == 2'd2) begin
                exp_rd = w;
            end else if (size == 2'd0) begin
                v = (w >> sh) & 32'hFF;
                if (!uns && v[7]) v = v | 32'hFFFFFF00;
                exp_rd = v;
            end else begin
                v = (w >> sh) & 32'hFFFF;
                if (!uns && v[15]) v = v | 32'hFFFF0000;
                exp_rd = v;
            end
            last_rdata = exp_rd;
        end

        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        wait_c = 0;
        while (!req_ready && wait_c < 10) begin
            @(negedge clk);
            wait_c++;
        end
        if (!req_ready) begin
            chk_eq("handshake", req_ready, 1'b1);
            req_valid = 1'b0;
            rd = '0;
            return;
        end
        if (b2b) chk_eq("b2b_wait", wait_c, 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        c = 0; wr = 0; waddr = -1;
        while (1) begin
            if (dm_wr) begin
                wr++;
                waddr = int'(dm_addr);
            end
            if (rsp_valid || c == 8) break;
            @(negedge clk);
            c++;
        end
        chk_eq("rsp_valid", rsp_valid, 1'b1);
        chk_eq("latency", c, exp_lat);
        chk_eq("rsp_err", rsp_err, exp_err);
        chk_eq("rsp_rdata", rsp_rdata, exp_rd);
        chk_eq("ready_in_done", req_ready, 1'b1);
        chk_eq("write_count", wr, exp_wr);
        if (exp_wr != 0) chk_eq("write_addr", waddr, idx);
        chk_eq("mem_word", mem[idx], ref_mem[idx]);
        rd = rsp_rdata;
    endtask

    initial begin
        int cnt, bad, idx;
        logic [31:0] a;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        last_rdata = '0;
        repeat (2) @(negedge clk);
        chk_eq("rst_req_ready", req_ready, 1'b0);
        chk_eq("rst_rsp_valid", rsp_valid, 1'b0);
        chk_eq("rst_rsp_err", rsp_err, 1'b0);
        chk_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk_eq("rst_dm_wr", dm_wr, 1'b0);
        chk_eq("rst_dm_addr", dm_addr, 32'h0);
        chk_eq("rst_dm_din", dm_din, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk_eq("post_rst_ready", req_ready, 1'b1);

        // Fill the working region back-to-back with word stores.
        for (int i = 0; i < 64; i++)
            do_req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, i != 0, got);
        idle(1);

        do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, 0, got);
        idle(1);
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, got);
        chk_eq("lw_deadbeef", got, 32'hDEADBEEF);

        do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344, 1, got);
        idle(1);
        do_req(1'b1, 2'd0, 1'b0, 32'h42, 32'h000000AA, 0, got);
        chk_eq("rmw_word16", mem[16], 32'h11AA3344);

        do_req(1'b1, 2'd2, 1'b0, 32'h50, 32'h80F07F85, 1, got);
        do_req(1'b0, 2'd0, 1'b0, 32'h50, 32'h0, 1, got);
        chk_eq("lb", got, 32'hFFFFFF85);
        do_req(1'b0, 2'd0, 1'b1, 32'h50, 32'h0, 1, got);
        chk_eq("lbu", got, 32'h00000085);
        do_req(1'b0, 2'd1, 1'b0, 32'h52, 32'h0, 1, got);
        chk_eq("lh", got, 32'hFFFF80F0);
        do_req(1'b0, 2'd1, 1'b1, 32'h52, 32'h0, 1, got);
        chk_eq("lhu", got, 32'h000080F0);

        do_req(1'b0, 2'd1, 1'b0, 32'h41, 32'h0, 1, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, 1, got);
        do_req(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 1, got);
        do_req(1'b1, 2'd3, 1'b0, 32'h44, 32'hCAFEF00D, 1, got);
        do_req(1'b1, 2'd1, 1'b0, 32'h45, 32'hBEEF, 1, got);
        idle(1);

        // Reset while a byte store sits in WAIT.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h77;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cnt = int'(dm_wr) + int'(rsp_valid);
        @(negedge clk);
        cnt += int'(dm_wr) + int'(rsp_valid);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_rdata = '0;
        #1;
        chk_eq("rst_abort_ready", req_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cnt += int'(dm_wr) + int'(rsp_valid);
        end
        chk_eq("rst_abort_activity", cnt, 0);
        chk_eq("rst_abort_mem", mem[8], ref_mem[8]);
        chk_eq("rst_abort_rdata", rsp_rdata, 32'h0);

        do_req(1'b1, 2'd2, 1'b0, 32'h10000004, 32'h5, 0, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 1, got);
        chk_eq("wrap_load", got, 32'h5);

        for (int n = 0; n < 400; n++) begin
            bit b2b;
            idx = $urandom_range(0, 63);
            a   = ($urandom & 32'hFFFFF000) | 32'(idx << 2) | 32'($urandom_range(0, 3));
            b2b = bit'($urandom_range(0, 1));
            if (!b2b) idle($urandom_range(1, 2));
            do_req(1'(($urandom_range(0, 1))), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, $urandom, b2b, got);
        end
        idle(1);

        bad = 0;
        for (int i = 0; i < 64; i++)
            if (mem[i] !== ref_mem[i]) bad++;
        chk_eq("final_mem_bad_words", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
